row_cache_arbiter: RTL
======================

Name: row_cache_arbiter

Overview:
- Shares one row-cache tag controller among NREQ requesters (bank/host ports) using round-robin arbitration. One operation is in flight at a time.
- Sequences each cache operation: issues the RD/WR pulse, waits for completion, and models DRAM fill latency on a miss by timing the cache's sync input.
- Returns the cache row index to the granted requester with a one-cycle ack.
- Sits between the requester-side front end and the cache block in the DRAM emulation path.

Parameters:
- NREQ, 4, number of requesters (≥2).
- CHWIDTH, 5, cache row index width.
- ADDRWIDTH, 17, DRAM row address width.
- MISSLAT, 8, cycles from first sampled c_hold to c_sync assertion (≥1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request.
- req_we  in  NREQ  1=write, 0=read.
- req_row  in  NREQ*ADDRWIDTH  packed row addresses; requester i at [i*ADDRWIDTH +: ADDRWIDTH].
- req_ack  out  NREQ  one-hot, one-cycle completion pulse.
- resp_crow  out  CHWIDTH  cache row index; valid while req_ack≠0.
- resp_miss  out  1  operation took the miss path; valid with req_ack.
- busy  out  1  high in any state except IDLE.
- c_rd  out  1  read command pulse to cache.
- c_wr  out  1  write command pulse to cache.
- c_row  out  ADDRWIDTH  row address to cache.
- c_sync  out  1  miss-resolution strobe to cache.
- c_hold  in  1  cache stalled on miss.
- c_done  in  1  cache operation complete; one-cycle pulse.
- c_crow  in  CHWIDTH  cache row index; sampled when c_done=1.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, latched grant/row/miss cleared. Any in-flight transaction is dropped and no ack is issued. Release is synchronous to clk.
- States: IDLE, ISSUE, WAIT, MISS, RESP. Encoding is free.
- IDLE:
  - If any req_valid, grant g = first set bit scanning rr_ptr, rr_ptr+1, … with wrap mod NREQ.
  - Latch g, req_we[g], req_row[g]; clear miss flag; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - c_wr=we_l, c_rd=!we_l; never both high.
  - c_row=row_l. c_row stays held until the state returns to IDLE, then drives 0.
  - Go to WAIT.
- WAIT:
  - c_done=1: capture c_crow, go to RESP. c_done takes priority over c_hold in the same cycle.
  - Else c_hold=1: set miss flag, load counter with MISSLAT-1, go to MISS.
  - Else stay in WAIT.
- MISS:
  - Counter decrements each cycle while nonzero.
  - When the counter is 0, c_sync=1 and stays high every cycle until c_done.
  - c_done=1 (including while counter>0): capture c_crow, deassert c_sync, go to RESP.
- RESP (1 cycle):
  - req_ack[g]=1, resp_crow=captured value, resp_miss=miss flag.
  - rr_ptr ← (g+1) mod NREQ; go to IDLE. A new grant is possible on the next cycle.
- Latency: ack asserts the cycle after c_done is sampled. Minimum request-to-ack is 3 cycles (grant, ISSUE, WAIT with c_done, RESP ack → 4th edge).
- Requester rules:
  - Hold valid/we/row until ack.
  - Requests are sampled only in IDLE; changes after grant have no effect on the current operation.
  - Deassertion after grant still produces the ack.
  - Deassertion before grant means the request is never served.
- c_hold and c_done are ignored in IDLE, ISSUE, and RESP.
- Counter width is $clog2(MISSLAT+1). The counter saturates at 0 (no wrap).
- rr_ptr wraps NREQ-1 → 0. Only the served requester advances the pointer, which guarantees no starvation.

Test Plan:
- Single hit: req_valid=0001, we=0, row=0x1ABC; cache returns c_done 1 cycle after c_rd with c_crow=5 → c_rd one pulse with c_row=0x1ABC; req_ack=0001 the cycle after c_done; resp_crow=5, resp_miss=0; c_sync never asserted.
- Write miss: req_valid=0100, we=1, row=0x00FF; c_hold raised the cycle after c_wr; c_done 2 cycles after c_sync, c_crow=31 → c_sync first high exactly 8 cycles after c_hold sampled, stays high until c_done; req_ack=0100, resp_miss=1, resp_crow=31.
- Round-robin fairness: req_valid=1111 held, each op hits → acks in order 0001, 0010, 0100, 1000, 0001; c_rd/c_wr never overlap; busy drops for exactly 1 cycle between ops.
- Pointer wrap and skip: rr_ptr=3 after serving requester 2, req_valid=0011 → requester 0 granted, then requester 1, then idle.
- Reset mid-miss: in MISS with counter=4, drive rst=0 → all outputs 0 immediately, no ack. After release, a pending req_valid=0010 is granted starting from rr_ptr=0 scan.
- Early c_done in MISS: c_hold then c_done while counter=6 → RESP next cycle, c_sync never asserted, resp_miss=1.

Source files
------------

// File: rtl/row_cache_arbiter.sv
// row_cache_arbiter: round-robin front end sharing one row-cache tag
// controller; sequences RD/WR, miss fill timing and the requester ack.
module row_cache_arbiter #(
  parameter int NREQ      = 4,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int MISSLAT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*ADDRWIDTH-1:0] req_row,
  output logic [NREQ-1:0]           req_ack,
  output logic [CHWIDTH-1:0]        resp_crow,
  output logic                      resp_miss,
  output logic                      busy,
  output logic                      c_rd,
  output logic                      c_wr,
  output logic [ADDRWIDTH-1:0]      c_row,
  output logic                      c_sync,
  input  logic                      c_hold,
  input  logic                      c_done,
  input  logic [CHWIDTH-1:0]        c_crow
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MISSLAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]           r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gnt;
  logic                 r_we;
  logic                 r_miss;
  logic [ADDRWIDTH-1:0] r_row;
  logic [CHWIDTH-1:0]   r_crow;
  logic [CW-1:0]        r_cnt;

  logic                 w_found;
  logic [PW-1:0]        w_gnt;
  logic [PW-1:0]        w_next;
  logic                 w_resp;

  // round-robin pick: first valid requester at or after the pointer
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_next = (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
  assign w_resp = (r_state == S_RESP);

  // operation sequencer; the grant is frozen until the ack is returned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_miss  <= 1'b0;
      r_row   <= '0;
      r_crow  <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt;
            r_we    <= req_we[w_gnt];
            r_row   <= req_row[w_gnt*ADDRWIDTH +: ADDRWIDTH];
            r_miss  <= 1'b0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (c_done) begin
            r_crow  <= c_crow;
            r_state <= S_RESP;
          end else if (c_hold) begin
            r_miss  <= 1'b1;
            r_cnt   <= CW'(MISSLAT - 1);
            r_state <= S_MISS;
          end
        end
        S_MISS: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (c_done) begin
            r_crow  <= c_crow;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ptr   <= w_next;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign c_rd      = (r_state == S_ISSUE) && !r_we;
  assign c_wr      = (r_state == S_ISSUE) && r_we;
  assign c_row     = busy ? r_row : '0;
  assign c_sync    = (r_state == S_MISS) && (r_cnt == '0);
  assign resp_crow = w_resp ? r_crow : '0;
  assign resp_miss = w_resp && r_miss;

  // one-hot ack to the granted requester during the response cycle
  always_comb begin
    req_ack = '0;
    if (w_resp) req_ack[r_gnt] = 1'b1;
  end
endmodule
